// File: rtl/vga_fb_control.sv
// Double-buffered frame-buffer controller: the producer fills the back bank and the VGA side scans the front bank.
// Bank swaps are committed only at a frame-end read. A clear engine blanks the back bank one word per cycle.
module vga_fb_control #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8,
   parameter int DEPTH = 2**ADDR_W,
   parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [ADDR_W-1:0] VGA_ADDR,
   input  logic              VGA_EN,
   output logic [DATA_W-1:0] VGA_DATA,
   output logic [DATA_W-1:0] VGA_DATA_N,
   output logic              VGA_VALID,
   input  logic              WR_VALID,
   output logic              WR_READY,
   input  logic [ADDR_W-1:0] WR_ADDR,
   input  logic [DATA_W-1:0] WR_DATA,
   input  logic              SWAP_REQ,
   input  logic              CLEAR_REQ,
   output logic              SWAP_PEND,
   output logic              FRONT_SEL,
   output logic              BUSY,
   output logic [15:0]       FRAME_CNT
);

   localparam int unsigned DEPTH_U = DEPTH;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   typedef enum logic {S_IDLE, S_CLEAR} state_t;

   state_t            state, state_next;
   logic [ADDR_W-1:0] clr_addr;
   logic              front_sel, swap_pend;
   logic [15:0]       frame_cnt;

   logic [DATA_W-1:0] bank0 [DEPTH];
   logic [DATA_W-1:0] bank1 [DEPTH];

   logic              frame_end, clr_done, commit, wr_fire, rd_in_range;
   logic              bank_we;
   logic [ADDR_W-1:0] bank_wa;
   logic [DATA_W-1:0] bank_wd;

   assign frame_end   = VGA_EN && (VGA_ADDR == LAST_ADDR);
   assign clr_done    = (state == S_CLEAR) && (clr_addr == LAST_ADDR);
   assign rd_in_range = 32'(VGA_ADDR) < DEPTH_U;
   // A request that arrives together with a clear waits for the clear to finish.
   assign commit      = frame_end && (state == S_IDLE) &&
                        (swap_pend || (SWAP_REQ && !CLEAR_REQ));

   // Handshake: a write transfers on any edge where WR_VALID && WR_READY; out-of-range
   // addresses still complete the handshake but are dropped.
   assign WR_READY = !RST && (state == S_IDLE) && !swap_pend;
   assign wr_fire  = WR_VALID && WR_READY && (32'(WR_ADDR) < DEPTH_U);

   assign SWAP_PEND = swap_pend;
   assign FRONT_SEL = front_sel;
   assign BUSY      = (state == S_CLEAR);
   assign FRAME_CNT = frame_cnt;

   always_ff @(posedge CLK) begin
      if (RST) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (CLEAR_REQ) state_next = S_CLEAR;
         S_CLEAR: if (clr_done)  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST)                  clr_addr <= '0;
      else if (state == S_IDLE) clr_addr <= '0;
      else if (!clr_done)       clr_addr <= clr_addr + ADDR_W'(1);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         swap_pend <= 1'b0;
         front_sel <= 1'b0;
         frame_cnt <= '0;
      end else begin
         if (commit) begin
            swap_pend <= 1'b0;
            front_sel <= ~front_sel;
         end else if (SWAP_REQ) begin
            swap_pend <= 1'b1;
         end
         if (frame_end) frame_cnt <= frame_cnt + 16'd1;
      end
   end

   // Single back-bank write port shared by the clear engine and the producer.
   always_comb begin
      bank_we = 1'b0;
      bank_wa = WR_ADDR;
      bank_wd = WR_DATA;
      if (state == S_CLEAR) begin
         bank_we = !RST;
         bank_wa = clr_addr;
         bank_wd = CLEAR_VAL;
      end else if (wr_fire) begin
         bank_we = 1'b1;
      end
   end

   always_ff @(posedge CLK) begin
      if (bank_we) begin
         if (front_sel) bank0[bank_wa] <= bank_wd;
         else           bank1[bank_wa] <= bank_wd;
      end
   end

   // Non-blocking reads of the same array give read-before-write on collisions.
   always_ff @(posedge CLK) begin
      if (RST) begin
         VGA_DATA   <= '0;
         VGA_DATA_N <= '0;
         VGA_VALID  <= 1'b0;
      end else begin
         VGA_VALID <= VGA_EN;
         if (VGA_EN) begin
            if (!rd_in_range) begin
               VGA_DATA   <= '0;
               VGA_DATA_N <= '0;
            end else if (front_sel) begin
               VGA_DATA   <= bank1[VGA_ADDR];
               VGA_DATA_N <= bank0[VGA_ADDR];
            end else begin
               VGA_DATA   <= bank0[VGA_ADDR];
               VGA_DATA_N <= bank1[VGA_ADDR];
            end
         end
      end
   end

endmodule

// File: doc/vga_fb_control.md
# vga_fb_control

Parametrised double-buffered frame-buffer controller between the pixel producer and the VGA scan-out logic. The producer writes into the back bank via a valid/ready handshake, and the VGA side reads the front bank by address. A bank swap is requested at any time and committed only at a frame boundary. The block also provides a back-bank clear engine, a next-frame preview output (VGA_DATA_N) and a frame counter.

## Interface
- ADDR_W, 16, pixel address width.
- DATA_W, 8, pixel width.
- DEPTH, 2**ADDR_W, pixels per bank; the last frame pixel is DEPTH-1.
- CLEAR_VAL, '0, value the clear engine writes.
- CLK  in  1  single clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- VGA_ADDR  in  ADDR_W  scan-out read address.
- VGA_EN  in  1  read strobe.
- VGA_DATA  out  DATA_W  front-bank pixel, registered.
- VGA_DATA_N  out  DATA_W  back-bank pixel at the same address, registered.
- VGA_VALID  out  1  VGA_EN delayed by one cycle.
- WR_VALID  in  1  producer write request.
- WR_READY  out  1  write accepted when WR_VALID && WR_READY.
- WR_ADDR  in  ADDR_W  back-bank write address.
- WR_DATA  in  DATA_W  back-bank write data.
- SWAP_REQ  in  1  single-cycle pulse that requests a bank swap.
- CLEAR_REQ  in  1  single-cycle pulse that requests a back-bank clear.
- SWAP_PEND  out  1  swap requested but not yet committed.
- FRONT_SEL  out  1  index of the current front bank.
- BUSY  out  1  clear engine active.
- FRAME_CNT  out  16  count of frame-end events.

## Operation
- Storage: two banks of DEPTH x DATA_W. Bank FRONT_SEL is read-only to the VGA port; bank ~FRONT_SEL is the back bank. Memory contents are not reset.
- FSM states:
  - IDLE -> CLEAR on CLEAR_REQ.
  - CLEAR walks clr_addr from 0 to DEPTH-1, writing CLEAR_VAL to the back bank, one word per cycle.
  - CLEAR -> IDLE after writing DEPTH-1.
  - CLEAR_REQ while in CLEAR is ignored.
- BUSY = (state == CLEAR).
- WR_READY = !RST && state == IDLE && !SWAP_PEND. Producer writes are stalled while a swap is pending, so a frame cannot be torn.
- Write address WR_ADDR >= DEPTH: the handshake completes and the data is discarded.
- Swap request: SWAP_REQ sets SWAP_PEND in any state. A second SWAP_REQ while pending has no further effect.
- Frame-end event: VGA_EN && VGA_ADDR == DEPTH-1.
- Swap commit: at a frame-end event with SWAP_PEND = 1 and state != CLEAR:
  - FRONT_SEL toggles and SWAP_PEND clears on the next edge.
  - The frame-end read itself uses the old front bank.
  - If state == CLEAR at the frame end, the swap waits for the next frame end after the clear completes.
- Simultaneous SWAP_REQ and CLEAR_REQ in IDLE: the clear runs first; the swap commits at the first frame end after the clear.
- FRAME_CNT increments on every frame-end event, swap or not, and wraps 0xFFFF -> 0.
- Reads:
  - VGA_DATA and VGA_DATA_N update only when VGA_EN = 1, otherwise they hold.
  - Read address >= DEPTH returns 0 on both outputs.
- Read/write collision on the back bank at the same address in the same cycle: VGA_DATA_N returns the old content (read-before-write). This rule also applies to clear writes.

## Timing
- Read latency: 1 cycle. VGA_EN and VGA_ADDR at edge N give VGA_DATA, VGA_DATA_N and VGA_VALID after edge N+1.
- Write: accepted data is visible on VGA_DATA_N from a read issued on the following cycle.
- Clear: takes exactly DEPTH cycles in CLEAR.
  - CLEAR_REQ at edge N gives BUSY = 1 from N+1 through N+DEPTH.
  - WR_READY returns to 1 at N+DEPTH+1 if no swap is pending.
- Swap:
  - SWAP_REQ at edge N gives SWAP_PEND = 1 after N+1.
  - Frame end at edge M gives FRONT_SEL toggled and SWAP_PEND = 0 after M+1.
  - A SWAP_REQ in the same cycle as a frame end commits at that frame end.
- Reset (RST = 1 at an edge) gives the following values after the edge:
  - state IDLE, FRONT_SEL 0, SWAP_PEND 0, BUSY 0.
  - FRAME_CNT 0, VGA_DATA 0, VGA_DATA_N 0, VGA_VALID 0.
  - WR_READY 0 while RST is high.
- Reset mid-clear or mid-pending aborts the operation; no partial swap survives.

## Test plan
Use ADDR_W=4, DEPTH=16, DATA_W=8, CLEAR_VAL=8'h00.
- Reset, then write 0x10+i to back address i for i = 0..15, sweep VGA_ADDR 0..15 with VGA_EN = 1 -> VGA_DATA_N = 0x10+i one cycle after each address; FRAME_CNT = 1 after the sweep.
- SWAP_REQ at VGA_ADDR = 5 mid-sweep -> SWAP_PEND = 1 and WR_READY = 0 until address 15 is read. FRONT_SEL = 1 after that edge, and the next sweep gives VGA_DATA = 0x10+i.
- CLEAR_REQ with SWAP_REQ in the same cycle -> BUSY high for 16 cycles. A frame end during the clear does not swap; the swap commits at the first frame end after BUSY falls, and the new front bank reads 0x00 everywhere.
- Write 0xAA to address 3 in the same cycle as a read of address 3 -> VGA_DATA_N shows the old value; a read on the next cycle shows 0xAA.
- RST asserted mid-clear at clr_addr = 7 with SWAP_PEND = 1 -> all outputs return to reset values after one edge; BUSY = 0 and SWAP_PEND = 0.
- Run 65 536 full frames -> FRAME_CNT wraps to 0.
